alu_sweep_sig: RTL and testbench

- Synthesisable, parametrised operand-sweep engine for the ALU. Replaces open-ended sweep-and-print benches.
- For a latched ALU operation, it drives every combination of operand A, optionally operand B, and optionally carry-in into a combinational ALU.
- It compresses each {flags, result} pair into a MISR signature and compares the final value with an expected value.
- It sits between a bench or debug controller and one ALU instance, and gives a single pass/fail result per operation.

---
 rtl/alu_sweep_sig.sv | 162 ++++++++++++++++
 tb/tb_alu_sweep_sig.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_sig.sv
// Operand-sweep engine: walks every {A, B, carry-in} combination through one
// combinational ALU, folds each response into a MISR and reports pass/fail.
module alu_sweep_sig #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned FLAGS_WIDTH = 4,
    parameter int unsigned OPER_WIDTH  = 4,
    parameter int unsigned CARRY_POS   = 0,
    parameter int unsigned SWEEP_B     = 1,
    parameter int unsigned SWEEP_C     = 1,
    parameter int unsigned SIG_WIDTH   = 16,
    parameter logic [SIG_WIDTH-1:0] POLY = 16'h1021
) (
    input  logic                                  master_clk,
    input  logic                                  master_rst_n,
    input  logic                                  start,
    input  logic [OPER_WIDTH-1:0]                 oper_in,
    input  logic [SIG_WIDTH-1:0]                  expected_sig,
    output logic [OPER_WIDTH-1:0]                 alu_oper,
    output logic [WIDTH-1:0]                      alu_a,
    output logic [WIDTH-1:0]                      alu_b,
    output logic [FLAGS_WIDTH-1:0]                alu_flags_in,
    input  logic [WIDTH-1:0]                      alu_out,
    input  logic [FLAGS_WIDTH-1:0]                alu_flags_out,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  pass,
    output logic [SIG_WIDTH-1:0]                  signature,
    output logic [WIDTH*(1+SWEEP_B)+SWEEP_C:0]    vec_count
);

    localparam int unsigned VEC_W    = WIDTH * (1 + SWEEP_B) + SWEEP_C;
    localparam int unsigned CNT_W    = VEC_W + 1;
    localparam int unsigned RESP_W   = FLAGS_WIDTH + WIDTH;
    localparam int unsigned N_CHUNKS = (RESP_W + SIG_WIDTH - 1) / SIG_WIDTH;
    localparam int unsigned PAD_W    = N_CHUNKS * SIG_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [VEC_W-1:0]        v_q, v_d;
    logic [OPER_WIDTH-1:0]   oper_q, oper_d;
    logic [SIG_WIDTH-1:0]    sig_q, sig_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pass_q, pass_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [PAD_W-1:0]        resp_pad;
    logic [SIG_WIDTH-1:0]    fold;
    logic [SIG_WIDTH-1:0]    sig_next;
    logic                    carry_bit;

    // Operand fields come straight from the vector counter: {A, B, C}.
    assign alu_a = v_q[VEC_W-1 -: WIDTH];

    generate
        if (SWEEP_B != 0) begin : g_sweep_b
            assign alu_b = v_q[SWEEP_C +: WIDTH];
        end else begin : g_hold_b
            assign alu_b = '0;
        end
    endgenerate

    assign carry_bit = (SWEEP_C != 0) ? v_q[0] : 1'b0;

    // Only the carry position of the flag vector is ever driven.
    always_comb begin
        alu_flags_in            = '0;
        alu_flags_in[CARRY_POS] = carry_bit;
    end

    // XOR-fold the zero-padded {flags, result} response into one MISR word.
    always_comb begin
        resp_pad = PAD_W'({alu_flags_out, alu_out});
        fold     = '0;
        for (int unsigned i = 0; i < N_CHUNKS; i++) begin
            fold = fold ^ resp_pad[i*SIG_WIDTH +: SIG_WIDTH];
        end
    end

    // One MISR step over the current signature.
    assign sig_next = (sig_q << 1) ^ (sig_q[SIG_WIDTH-1] ? POLY : '0) ^ fold;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        oper_d  = oper_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                v_d = '0;
                if (start) begin
                    oper_d  = oper_in;
                    sig_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sig_d = sig_next;
                cnt_d = cnt_q + CNT_W'(1);
                v_d   = v_q + VEC_W'(1);
                if (v_q == '1) begin
                    // Judge against the final signature so pass is valid alongside done.
                    pass_d  = (sig_next == expected_sig);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any sweep in progress.
    always_ff @(posedge master_clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            oper_q  <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            oper_q  <= oper_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign alu_oper  = oper_q;
    assign signature = sig_q;
    assign vec_count = cnt_q;
    assign pass      = pass_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_sweep_sig.sv
// Directed bench for alu_sweep_sig: three instances with different sweep
// configurations and stub ALUs, driven one after another.
module tb_alu_sweep_sig;

    logic master_clk = 1'b0;
    logic master_rst_n;
    always #5 master_clk = ~master_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge master_clk);
        #1;
    endtask

    // Small instance: WIDTH=2, A only, ALU echoes A.
    logic        s_start;
    logic [3:0]  s_oper_in, s_oper, s_fin, s_fout;
    logic [15:0] s_exp, s_sig;
    logic [1:0]  s_a, s_b, s_out;
    logic        s_busy, s_done, s_pass;
    logic [2:0]  s_cnt;
    assign s_out  = s_a;
    assign s_fout = 4'h0;

    alu_sweep_sig #(.WIDTH(2), .SWEEP_B(0), .SWEEP_C(0)) u_small (
        .master_clk(master_clk), .master_rst_n(master_rst_n), .start(s_start),
        .oper_in(s_oper_in), .expected_sig(s_exp), .alu_oper(s_oper), .alu_a(s_a),
        .alu_b(s_b), .alu_flags_in(s_fin), .alu_out(s_out), .alu_flags_out(s_fout),
        .busy(s_busy), .done(s_done), .pass(s_pass), .signature(s_sig), .vec_count(s_cnt));

    // Mid instance: WIDTH=4, A, B and carry swept, ALU always returns zero.
    logic        m_start;
    logic [3:0]  m_oper_in, m_oper, m_fin, m_fout;
    logic [15:0] m_exp, m_sig;
    logic [3:0]  m_a, m_b, m_out;
    logic        m_busy, m_done, m_pass;
    logic [9:0]  m_cnt;
    assign m_out  = 4'h0;
    assign m_fout = 4'h0;

    alu_sweep_sig #(.WIDTH(4), .SWEEP_B(1), .SWEEP_C(1)) u_mid (
        .master_clk(master_clk), .master_rst_n(master_rst_n), .start(m_start),
        .oper_in(m_oper_in), .expected_sig(m_exp), .alu_oper(m_oper), .alu_a(m_a),
        .alu_b(m_b), .alu_flags_in(m_fin), .alu_out(m_out), .alu_flags_out(m_fout),
        .busy(m_busy), .done(m_done), .pass(m_pass), .signature(m_sig), .vec_count(m_cnt));

    // Adder instance: WIDTH=4, A and B swept, stub adder with optional fault.
    logic        a_start, fault_en;
    logic [3:0]  a_oper_in, a_oper, a_fin, a_fout;
    logic [15:0] a_exp, a_sig;
    logic [3:0]  a_a, a_b, a_out;
    logic [4:0]  a_sum;
    logic        a_busy, a_done, a_pass;
    logic [8:0]  a_cnt;
    assign a_sum  = 5'(a_a) + 5'(a_b) + 5'(a_fin[0]);
    assign a_out  = ((a_oper == 4'h1) ? a_sum[3:0] : (a_a ^ a_b))
                  ^ {3'b000, (fault_en && ({a_a, a_b} == 8'h12))};
    assign a_fout = {2'b00, (a_sum[3:0] == 4'h0), a_sum[4]};

    alu_sweep_sig #(.WIDTH(4), .SWEEP_B(1), .SWEEP_C(0)) u_add (
        .master_clk(master_clk), .master_rst_n(master_rst_n), .start(a_start),
        .oper_in(a_oper_in), .expected_sig(a_exp), .alu_oper(a_oper), .alu_a(a_a),
        .alu_b(a_b), .alu_flags_in(a_fin), .alu_out(a_out), .alu_flags_out(a_fout),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .vec_count(a_cnt));

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] f);
        return (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ f;
    endfunction

    // Reference signature for the adder sweep (A high nibble, B low nibble).
    function automatic logic [15:0] add_golden(input bit fault);
        logic [15:0] s;
        logic [7:0]  v;
        logic [4:0]  sum;
        logic [3:0]  o;
        logic [3:0]  f;
        s = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            v   = 8'(i);
            sum = 5'(v[7:4]) + 5'(v[3:0]);
            o   = sum[3:0];
            if (fault && (v == 8'h12)) o[0] = ~o[0];
            f   = {2'b00, (sum[3:0] == 4'h0), sum[4]};
            s   = misr(s, {8'h00, f, o});
        end
        return s;
    endfunction

    logic [15:0] seq1 [4];
    logic        busy_pat [12];
    logic        done_pat [12];
    logic [15:0] g0, g1;
    int          k;

    initial begin
        seq1     = '{16'h0000, 16'h0001, 16'h0000, 16'h0003};
        busy_pat = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
        done_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        master_rst_n = 1'b0;
        s_start = 0; m_start = 0; a_start = 0; fault_en = 0;
        s_oper_in = 4'h0; m_oper_in = 4'h0; a_oper_in = 4'h0;
        s_exp = 16'h0; m_exp = 16'h0; a_exp = 16'h0;
        repeat (2) tick;

        // Reset values.
        check_eq("rst_busy", 32'(s_busy), 32'd0);
        check_eq("rst_done", 32'(s_done), 32'd0);
        check_eq("rst_pass", 32'(s_pass), 32'd0);
        check_eq("rst_sig", 32'(s_sig), 32'd0);
        check_eq("rst_cnt", 32'(s_cnt), 32'd0);
        check_eq("rst_oper", 32'(s_oper), 32'd0);
        check_eq("rst_a", 32'(s_a), 32'd0);
        check_eq("rst_mid_fin", 32'(m_fin), 32'd0);
        check_eq("rst_add_cnt", 32'(a_cnt), 32'd0);
        master_rst_n = 1'b1;
        tick;

        // Basic A-only sweep, matching expected signature.
        s_oper_in = 4'h5; s_exp = 16'h0003; s_start = 1;
        tick;
        s_start = 0;
        check_eq("t1_oper", 32'(s_oper), 32'h5);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_a", 32'(s_a), 32'(i));
            check_eq("t1_busy", 32'(s_busy), 32'd1);
            check_eq("t1_nodone", 32'(s_done), 32'd0);
            tick;
            check_eq("t1_sig", 32'(s_sig), 32'(seq1[i]));
        end
        check_eq("t1_done", 32'(s_done), 32'd1);
        check_eq("t1_busy_end", 32'(s_busy), 32'd0);
        check_eq("t1_pass", 32'(s_pass), 32'd1);
        check_eq("t1_cnt", 32'(s_cnt), 32'd4);
        check_eq("t1_b", 32'(s_b), 32'd0);
        check_eq("t1_fin", 32'(s_fin), 32'd0);
        tick;
        check_eq("t1_done_pulse", 32'(s_done), 32'd0);
        check_eq("t1_pass_hold", 32'(s_pass), 32'd1);
        check_eq("t1_sig_hold", 32'(s_sig), 32'h3);
        check_eq("t1_cnt_hold", 32'(s_cnt), 32'd4);

        // Same sweep against a wrong golden value.
        s_exp = 16'h0004; s_start = 1;
        tick;
        s_start = 0;
        repeat (4) tick;
        check_eq("t2_done", 32'(s_done), 32'd1);
        check_eq("t2_pass", 32'(s_pass), 32'd0);
        check_eq("t2_sig", 32'(s_sig), 32'h3);
        tick;

        // start held high: back-to-back sweeps, oper_in change seen only in the second.
        s_exp = 16'h0003; s_oper_in = 4'h3; s_start = 1;
        for (int c = 0; c < 12; c++) begin
            tick;
            check_eq("t5_busy", 32'(s_busy), 32'(busy_pat[c]));
            check_eq("t5_done", 32'(s_done), 32'(done_pat[c]));
            if (c == 1) s_oper_in = 4'hA;
            if (c == 2) check_eq("t5_oper1", 32'(s_oper), 32'h3);
            if (c == 4) check_eq("t5_pass1", 32'(s_pass), 32'd1);
            if (c == 6) check_eq("t5_oper2", 32'(s_oper), 32'hA);
            if (c == 9) s_start = 0;
            if (c == 10) check_eq("t5_pass2", 32'(s_pass), 32'd1);
        end

        // Full A/B/carry sweep with a zero ALU: field ordering and length.
        m_oper_in = 4'h7; m_exp = 16'h0000; m_start = 1;
        tick;
        m_start = 0;
        k = 0;
        while (m_busy && k < 600) begin
            check_eq("t3_fin", 32'(m_fin), 32'({3'b000, k[0]}));
            check_eq("t3_b", 32'(m_b), 32'(k[4:1]));
            check_eq("t3_a", 32'(m_a), 32'(k[8:5]));
            tick;
            k++;
        end
        check_eq("t3_len", 32'(k), 32'd512);
        check_eq("t3_done", 32'(m_done), 32'd1);
        check_eq("t3_sig", 32'(m_sig), 32'd0);
        check_eq("t3_cnt", 32'(m_cnt), 32'd512);
        check_eq("t3_pass", 32'(m_pass), 32'd1);
        check_eq("t3_oper", 32'(m_oper), 32'h7);
        tick;

        // Adder sweep against the reference signature, then with a planted fault.
        g0 = add_golden(1'b0);
        g1 = add_golden(1'b1);
        a_oper_in = 4'h1; a_exp = g0; a_start = 1;
        tick;
        a_start = 0;
        k = 0;
        while (!a_done && k < 300) begin
            tick;
            k++;
        end
        check_eq("t6_len", 32'(k), 32'd256);
        check_eq("t6_pass", 32'(a_pass), 32'd1);
        check_eq("t6_sig", 32'(a_sig), 32'(g0));
        check_eq("t6_cnt", 32'(a_cnt), 32'd256);
        check_eq("t6_oper", 32'(a_oper), 32'h1);
        tick;

        fault_en = 1; a_start = 1;
        tick;
        a_start = 0;
        k = 0;
        while (!a_done && k < 300) begin
            tick;
            k++;
        end
        check_eq("t6f_done", 32'(a_done), 32'd1);
        check_eq("t6f_pass", 32'(a_pass), 32'd0);
        check_eq("t6f_sig", 32'(a_sig), 32'(g1));
        tick;
        fault_en = 0;

        // Reset pulse mid-sweep at vector 5, then an undisturbed rerun.
        a_start = 1;
        tick;
        a_start = 0;
        k = 0;
        while (a_cnt != 9'd5 && k < 50) begin
            tick;
            k++;
        end
        check_eq("t4_vec_a", 32'(a_a), 32'd0);
        check_eq("t4_vec_b", 32'(a_b), 32'd5);
        master_rst_n = 1'b0;
        #1;
        check_eq("t4_busy", 32'(a_busy), 32'd0);
        check_eq("t4_done", 32'(a_done), 32'd0);
        check_eq("t4_pass", 32'(a_pass), 32'd0);
        check_eq("t4_sig", 32'(a_sig), 32'd0);
        check_eq("t4_cnt", 32'(a_cnt), 32'd0);
        check_eq("t4_a", 32'(a_a), 32'd0);
        check_eq("t4_b", 32'(a_b), 32'd0);
        check_eq("t4_oper", 32'(a_oper), 32'd0);
        check_eq("t4_fin", 32'(a_fin), 32'd0);
        #4;
        master_rst_n = 1'b1;
        tick;
        check_eq("t4_idle", 32'(a_busy), 32'd0);
        a_start = 1;
        tick;
        a_start = 0;
        k = 0;
        while (!a_done && k < 300) begin
            tick;
            k++;
        end
        check_eq("t4_rerun_len", 32'(k), 32'd256);
        check_eq("t4_rerun_pass", 32'(a_pass), 32'd1);
        check_eq("t4_rerun_sig", 32'(a_sig), 32'(g0));
        check_eq("t4_rerun_cnt", 32'(a_cnt), 32'd256);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
